// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: rotating active-low row drive, synchronized column
// sense, whole-scan accumulation and scan-level debounce producing a key code strobe.
module keypad_scanner_4x4 #(
  parameter int unsigned SCAN_DIV       = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_held
);

  // state     | meaning
  // IDLE      | no key accepted, waiting for a single-key scan
  // CAND      | same single key seen on cnt_q consecutive scans
  // PRESSED   | key accepted, key_held high
  // RELEASING | accepted key missing on cnt_q consecutive scans
  typedef enum logic [1:0] {IDLE, CAND, PRESSED, RELEASING} state_t;

  localparam int unsigned    DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]  DWELL_ONE  = DW'(1);
  localparam logic [3:0]     DEB        = 4'(DEBOUNCE_SCANS);
  localparam bit             DEB_ONE    = (DEBOUNCE_SCANS == 1);

  logic [3:0]    col_meta_q, col_sync_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    row_idx_q;
  logic [1:0]    acc_n_q, acc_n_d;
  logic [3:0]    acc_code_q, acc_code_d;
  state_t        state_q;
  logic [3:0]    cand_q, cnt_q, key_value_q;
  logic          key_valid_q, key_held_q;

  logic [3:0] col_low;
  logic [2:0] row_ones;
  logic [1:0] row_col;
  logic       sample, scan_done, res_single;
  logic [1:0] m_n;
  logic [3:0] m_code;

  assign row = ~(4'b0001 << row_idx_q);

  // acc_n counts keys seen so far this scan, saturating at 2 (= multi)
  always_comb begin
    col_low  = ~col_sync_q;
    row_ones = 3'(col_low[0]) + 3'(col_low[1]) + 3'(col_low[2]) + 3'(col_low[3]);
    row_col  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (col_low[i]) row_col = i[1:0];
    end
    m_n    = acc_n_q;
    m_code = acc_code_q;
    if (row_ones == 3'd1) begin
      m_n = (acc_n_q == 2'd0) ? 2'd1 : 2'd2;
      if (acc_n_q == 2'd0) m_code = {row_idx_q, row_col};
    end else if (row_ones != 3'd0) begin
      m_n = 2'd2;
    end
    sample     = (dwell_q == DWELL_LAST);
    scan_done  = sample && (row_idx_q == 2'd3);
    res_single = scan_done && (m_n == 2'd1);
    acc_n_d    = acc_n_q;
    acc_code_d = acc_code_q;
    if (sample) begin
      acc_n_d    = scan_done ? 2'd0 : m_n;
      acc_code_d = scan_done ? 4'd0 : m_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
      dwell_q    <= '0;
      row_idx_q  <= 2'd0;
      acc_n_q    <= 2'd0;
      acc_code_q <= 4'd0;
    end else begin
      col_meta_q <= col;
      col_sync_q <= col_meta_q;
      acc_n_q    <= acc_n_d;
      acc_code_q <= acc_code_d;
      if (sample) begin
        dwell_q   <= '0;
        row_idx_q <= row_idx_q + 2'd1;
      end else begin
        dwell_q <= dwell_q + DWELL_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cand_q      <= 4'd0;
      cnt_q       <= 4'd0;
      key_value_q <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (scan_done) begin
        case (state_q)
          IDLE: begin
            if (res_single) begin
              if (DEB_ONE) begin
                state_q     <= PRESSED;
                key_value_q <= m_code;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= 4'd0;
              end else begin
                state_q <= CAND;
                cand_q  <= m_code;
                cnt_q   <= 4'd1;
              end
            end
          end
          CAND: begin
            if (res_single && (m_code == cand_q)) begin
              if (cnt_q + 4'd1 == DEB) begin
                state_q     <= PRESSED;
                key_value_q <= cand_q;
                key_valid_q <= 1'b1;
                key_held_q  <= 1'b1;
                cnt_q       <= 4'd0;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else if (res_single) begin
              cand_q <= m_code;
              cnt_q  <= 4'd1;
            end else begin
              state_q <= IDLE;
              cnt_q   <= 4'd0;
            end
          end
          PRESSED: begin
            if (!(res_single && (m_code == key_value_q))) begin
              if (DEB_ONE) begin
                state_q    <= IDLE;
                key_held_q <= 1'b0;
                cnt_q      <= 4'd0;
              end else begin
                state_q <= RELEASING;
                cnt_q   <= 4'd1;
              end
            end
          end
          RELEASING: begin
            if (res_single && (m_code == key_value_q)) begin
              state_q <= PRESSED;
              cnt_q   <= 4'd0;
            end else if (cnt_q + 4'd1 == DEB) begin
              state_q    <= IDLE;
              key_held_q <= 1'b0;
              cnt_q      <= 4'd0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign key_value = key_value_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
